// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold a count from 0 up to and including w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // Two's-complement negate on a 64-bit container; callers truncate.
    function automatic logic [63:0] twos_neg(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    // Conditional negate: the magnitude of a negative operand, or the signed product.
    function automatic logic [63:0] cond_neg(input logic [63:0] x, input logic is_neg);
        return is_neg ? twos_neg(x) : x;
    endfunction

endpackage

// File: rtl/seq_multiplier_datapath.sv
// Operand magnitude capture, shift-add accumulator and final sign fix-up.
// SEQ_MULTIPLIER_EARLY_EXIT_EN exposes the remaining-multiplier-is-zero flag.
module seq_multiplier_datapath
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    output logic               mult_zero_c,
`endif
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] mult;
    logic             neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    assign mult_zero_c = (mult == '0);
`endif

    // Magnitudes of the incoming operands; -2^(W-1) maps to 2^(W-1) unsigned.
    always_comb begin
        a_mag = WIDTH'(cond_neg(64'(a), signed_mode & a[WIDTH-1]));
        b_mag = WIDTH'(cond_neg(64'(b), signed_mode & b[WIDTH-1]));
    end

    // Capture on load, retire one multiplier bit per step, publish on finish.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand   <= '0;
            acc     <= '0;
            mult    <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                mcand <= PW'(a_mag);
                mult  <= b_mag;
                acc   <= '0;
                neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (step) begin
                if (mult[0]) begin
                    acc <= acc + mcand;
                end
                mcand <= mcand << 1;
                mult  <= mult >> 1;
            end
            if (finish) begin
                product <= PW'(cond_neg(64'(acc), neg));
            end
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with start/done handshake.
// Define SEQ_MULTIPLIER_EARLY_EXIT_EN to finish as soon as the multiplier remainder is zero.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_c;
    logic             step_c;
    logic             finish_c;

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    logic mult_zero_c;

    // Finish once every bit is retired, or once at least one bit is done and none remain set.
    assign finish_c = (state == RUN) &&
                      ((cnt == '0) || (mult_zero_c && (cnt != CNT_W'(WIDTH))));
`else
    // Finish once every multiplier bit has been retired.
    assign finish_c = (state == RUN) && (cnt == '0);
`endif

    assign load_c = start && ((state == IDLE) || (state == DONE));
    assign step_c = (state == RUN) && !finish_c;

    // Control FSM: bit counter plus registered busy/done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        cnt   <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (finish_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        cnt   <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    seq_multiplier_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clock       (clock),
        .reset       (reset),
        .load        (load_c),
        .step        (step_c),
        .finish      (finish_c),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
        .mult_zero_c (mult_zero_c),
`endif
        .product     (product)
    );

endmodule
